// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipeline_hazard_ctrl                                   |
// | Description : Stall / flush / halt sequencer for the 5-stage core.   |
// |               Decodes mem freeze, HALT, taken branch and load-use    |
// |               hazards into PC / pipeline enables and stage flushes,  |
// |               and keeps saturating stall and flush counters.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             branch_taken,
   input  logic             halt_ex,
   input  logic             load_ex,
   input  logic [2:0]       ex_rd,
   input  logic [2:0]       id_rs1,
   input  logic [2:0]       id_rs2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic             mem_busy,
   output logic             enablePC,
   output logic             enable_ifid,
   output logic             pipe_en,
   output logic             imJumpFlag,
   output logic             Flush1,
   output logic             Flush2,
   output logic             Flush3,
   output logic             HALT,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_FLUSH  = 3'd2,
      S_DRAIN  = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   localparam logic [2:0]       FLUSH_LD = 3'(FLUSH_CYCLES);
   localparam logic [2:0]       DRAIN_LD = 3'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [2:0]       dcnt_q, dcnt_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             stall_inc, flush_inc;
   logic             load_use;

   // R0 is an ordinary register here, so no zero-register exclusion
   assign load_use = load_ex & ((id_use1 & (id_rs1 == ex_rd)) |
                                (id_use2 & (id_rs2 == ex_rd)));

   // Next-state and output decode; event priority: freeze > halt > branch > load-use
   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      enablePC    = 1'b0;
      enable_ifid = 1'b0;
      pipe_en     = 1'b0;
      imJumpFlag  = 1'b0;
      Flush1      = 1'b0;
      Flush2      = 1'b0;
      Flush3      = 1'b0;
      HALT        = 1'b0;
      case (state_q)
         S_RUN, S_FLUSH: begin
            enablePC    = 1'b1;
            enable_ifid = 1'b1;
            pipe_en     = 1'b1;
            if (mem_busy) begin
               // Whole pipeline frozen; other events wait for the release
               enablePC    = 1'b0;
               enable_ifid = 1'b0;
               pipe_en     = 1'b0;
               stall_inc   = 1'b1;
            end else if (halt_ex) begin
               enablePC = 1'b0;
               Flush1   = 1'b1;
               Flush2   = 1'b1;
               dcnt_d   = DRAIN_LD;
               state_d  = S_DRAIN;
            end else if (branch_taken) begin
               imJumpFlag = 1'b1;
               Flush1     = 1'b1;
               Flush2     = 1'b1;
               flush_inc  = 1'b1;
               if (FLUSH_LD != 3'd0) begin
                  dcnt_d  = FLUSH_LD;
                  state_d = S_FLUSH;
               end else begin
                  state_d = S_RUN;
               end
            end else if ((state_q == S_RUN) && load_use) begin
               // One bubble into EX while PC and IF/ID hold
               enablePC    = 1'b0;
               enable_ifid = 1'b0;
               Flush2      = 1'b1;
               stall_inc   = 1'b1;
            end else if (state_q == S_FLUSH) begin
               Flush1 = 1'b1;
               dcnt_d = dcnt_q - 3'd1;
               if (dcnt_q <= 3'd1) begin
                  state_d = S_RUN;
               end
            end
         end
         S_DRAIN: begin
            Flush1  = 1'b1;
            Flush2  = 1'b1;
            pipe_en = ~mem_busy;
            if (!mem_busy) begin
               dcnt_d = dcnt_q - 3'd1;
               if (dcnt_q <= 3'd1) begin
                  state_d = S_HALTED;
               end
            end
         end
         S_HALTED: begin
            HALT = 1'b1;
         end
         default: begin
            // IDLE and any unlisted encoding: clear the pipe, start fetch next cycle
            pipe_en = 1'b1;
            Flush1  = 1'b1;
            Flush2  = 1'b1;
            Flush3  = 1'b1;
            state_d = S_RUN;
         end
      endcase
   end

   // State, down-counter and saturating performance counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         dcnt_q      <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pipeline_hazard_ctrl                                |
// | Description : Self-checking bench for pipeline_hazard_ctrl.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

   // Output vector order: {enablePC, enable_ifid, pipe_en, imJumpFlag, Flush1, Flush2, Flush3, HALT}
   localparam logic [7:0] O_IDLE  = 8'b0010_1110;
   localparam logic [7:0] O_RUN   = 8'b1110_0000;
   localparam logic [7:0] O_BR    = 8'b1111_1100;
   localparam logic [7:0] O_FLSH  = 8'b1110_1000;
   localparam logic [7:0] O_LU    = 8'b0010_0100;
   localparam logic [7:0] O_BUSY  = 8'b0000_0000;
   localparam logic [7:0] O_HLTEX = 8'b0110_1100;
   localparam logic [7:0] O_DRN   = 8'b0010_1100;
   localparam logic [7:0] O_DRNB  = 8'b0000_1100;
   localparam logic [7:0] O_HALT  = 8'b0000_0001;

   typedef struct {
      string       name;
      logic        rst_n, br, halt, load;
      logic [2:0]  ex_rd, rs1, rs2;
      logic        u1, u2, busy;
      logic [7:0]  out;
      logic [15:0] stall, flush;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, reset_s;
   logic        branch_taken, halt_ex, load_ex, id_use1, id_use2, mem_busy;
   logic [2:0]  ex_rd, id_rs1, id_rs2;
   logic        enablePC, enable_ifid, pipe_en, imJumpFlag, Flush1, Flush2, Flush3, HALT;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_enablePC, s_enable_ifid, s_pipe_en, s_imJumpFlag;
   logic        s_Flush1, s_Flush2, s_Flush3, s_HALT;
   logic [2:0]  s_stall_cnt, s_flush_cnt;
   logic [7:0]  out_vec;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   assign out_vec = {enablePC, enable_ifid, pipe_en, imJumpFlag, Flush1, Flush2, Flush3, HALT};

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .branch_taken(branch_taken), .halt_ex(halt_ex),
      .load_ex(load_ex), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2), .mem_busy(mem_busy),
      .enablePC(enablePC), .enable_ifid(enable_ifid), .pipe_en(pipe_en),
      .imJumpFlag(imJumpFlag), .Flush1(Flush1), .Flush2(Flush2), .Flush3(Flush3),
      .HALT(HALT), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter instance for the saturation corner
   pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .DRAIN_CYCLES(2), .CNT_W(3)) dut_sat (
      .clk(clk), .reset(reset_s), .branch_taken(branch_taken), .halt_ex(halt_ex),
      .load_ex(load_ex), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2), .mem_busy(mem_busy),
      .enablePC(s_enablePC), .enable_ifid(s_enable_ifid), .pipe_en(s_pipe_en),
      .imJumpFlag(s_imJumpFlag), .Flush1(s_Flush1), .Flush2(s_Flush2), .Flush3(s_Flush3),
      .HALT(s_HALT), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   function automatic vec_t v(input string n, input logic r, input logic b, input logic h,
                              input logic l, input logic [2:0] rd, input logic [2:0] s1,
                              input logic [2:0] s2, input logic a1, input logic a2,
                              input logic bz, input logic [7:0] o, input logic [15:0] sc,
                              input logic [15:0] fc);
      vec_t x;
      x.name = n; x.rst_n = r; x.br = b; x.halt = h; x.load = l;
      x.ex_rd = rd; x.rs1 = s1; x.rs2 = s2; x.u1 = a1; x.u2 = a2; x.busy = bz;
      x.out = o; x.stall = sc; x.flush = fc;
      return x;
   endfunction

   task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, then compare mid-cycle
   task automatic step(input vec_t r);
      vec_t e;
      @(posedge clk);
      #1;
      reset = r.rst_n; branch_taken = r.br; halt_ex = r.halt; load_ex = r.load;
      ex_rd = r.ex_rd; id_rs1 = r.rs1; id_rs2 = r.rs2;
      id_use1 = r.u1; id_use2 = r.u2; mem_busy = r.busy;
      exp_q.push_back(r);
      #3;
      e = exp_q.pop_front();
      check({e.name, ".out"},   {8'h00, out_vec}, {8'h00, e.out});
      check({e.name, ".stall"}, stall_cnt, e.stall);
      check({e.name, ".flush"}, flush_cnt, e.flush);
   endtask

   initial begin
      reset = 1'b0; reset_s = 1'b0;
      branch_taken = 1'b0; halt_ex = 1'b0; load_ex = 1'b0; mem_busy = 1'b0;
      ex_rd = 3'd0; id_rs1 = 3'd0; id_rs2 = 3'd0; id_use1 = 1'b0; id_use2 = 1'b0;
      repeat (2) @(posedge clk);

      //            name         rst br h  ld rd    rs1   rs2   u1 u2 bz  out      stall fl
      tbl.push_back(v("reset",     0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_IDLE,  16'd0, 16'd0));
      tbl.push_back(v("idle",      1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_IDLE,  16'd0, 16'd0));
      tbl.push_back(v("run",       1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_RUN,   16'd0, 16'd0));
      tbl.push_back(v("branch",    1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_BR,    16'd0, 16'd0));
      tbl.push_back(v("flush_tl",  1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_FLSH,  16'd0, 16'd1));
      tbl.push_back(v("back_run",  1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_RUN,   16'd0, 16'd1));
      tbl.push_back(v("load_use",  1, 0, 0, 1, 3'd3, 3'd0, 3'd3, 0, 1, 0, O_LU,    16'd0, 16'd1));
      tbl.push_back(v("no_use",    1, 0, 0, 1, 3'd3, 3'd3, 3'd3, 0, 0, 0, O_RUN,   16'd1, 16'd1));
      tbl.push_back(v("r0_match",  1, 0, 0, 1, 3'd0, 3'd0, 3'd5, 1, 0, 0, O_LU,    16'd1, 16'd1));
      tbl.push_back(v("busy1",     1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, O_BUSY,  16'd2, 16'd1));
      tbl.push_back(v("busy2",     1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, O_BUSY,  16'd3, 16'd1));
      tbl.push_back(v("busy3",     1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, O_BUSY,  16'd4, 16'd1));
      tbl.push_back(v("br_release",1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_BR,    16'd5, 16'd1));
      tbl.push_back(v("br_reload", 1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_BR,    16'd5, 16'd2));
      tbl.push_back(v("flush_nolu",1, 0, 0, 1, 3'd3, 3'd0, 3'd3, 0, 1, 0, O_FLSH,  16'd5, 16'd3));
      tbl.push_back(v("halt_ex",   1, 1, 1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_HLTEX, 16'd5, 16'd3));
      tbl.push_back(v("drain_busy",1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, O_DRNB,  16'd5, 16'd3));
      tbl.push_back(v("drain2",    1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_DRN,   16'd5, 16'd3));
      tbl.push_back(v("drain1",    1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_DRN,   16'd5, 16'd3));
      tbl.push_back(v("halted",    1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_HALT,  16'd5, 16'd3));
      foreach (tbl[i]) step(tbl[i]);

      // HALTED must persist regardless of events until reset
      for (int i = 0; i < 20; i++) begin
         step(v("halt_hold", 1, i[0], i[1], 0, 3'd0, 3'd0, 3'd0, 0, 0, i[2], O_HALT, 16'd5, 16'd3));
      end

      // Reset pulse out of HALTED: state and counters clear on the edge
      step(v("rst_pulse", 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_HALT, 16'd5, 16'd3));
      step(v("rst_idle",  1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_IDLE, 16'd0, 16'd0));
      step(v("rst_run",   1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, O_RUN,  16'd0, 16'd0));

      // Saturation on the 3-bit counter instance: reach max-1, then keep freezing
      @(posedge clk); #1; reset_s = 1'b1; mem_busy = 1'b0;
      @(posedge clk); #1;                     // sat instance now in RUN
      mem_busy = 1'b1;
      for (int i = 0; i < 11; i++) begin
         #3;
         check("sat_stall", {13'd0, s_stall_cnt}, (i > 7) ? 16'd7 : 16'(i));
         @(posedge clk); #1;
      end
      mem_busy = 1'b0;
      #3;
      check("sat_hold", {13'd0, s_stall_cnt}, 16'd7);
      check("sat_flush", {13'd0, s_flush_cnt}, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
